// File: rtl/alu_seq_if.sv
// Operand/op handshake and result/flag handshake bundle for alu_seq.
// The master drives operands and out_ready; the slave (the ALU) drives results and flags.
interface alu_seq_if #(
    parameter int unsigned N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         carry;
    logic         overflow;
    logic         zero;
    logic         negative;
    logic         busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, carry, overflow, zero, negative, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, carry, overflow, zero, negative, busy
    );
endinterface

// File: rtl/alu_seq.sv
// Registered execute-stage ALU with handshaked operands and results.
// Single-cycle ops finish at the accept edge; MUL runs N shift-add iterations.
module alu_seq #(
    parameter int unsigned N = 32
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    localparam int unsigned SW = $clog2(N);
    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] CntLast = CW'(N - 1);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpSlt = 3'b101;
    localparam logic [2:0] OpSll = 3'b110;
    localparam logic [2:0] OpMul = 3'b111;

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e state_q, state_d;

    logic [N-1:0]  mcand_q, mplier_q, acc_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  result_q;
    logic          carry_q, ovf_q, zero_q, neg_q;

    logic          accept;
    logic          mul_last;
    logic [N-1:0]  mul_acc_next;

    logic [N:0]    sum_add, sum_sub;
    logic          ovf_add, ovf_sub;
    logic [N-1:0]  alu_res;
    logic          alu_c, alu_o;

    assign accept   = bus.in_valid && bus.in_ready;
    assign mul_last = (cnt_q == CntLast);

    // Subtraction as a + ~b + 1 so the carry-out reads as "no borrow".
    assign sum_add = {1'b0, bus.a} + {1'b0, bus.b};
    assign sum_sub = {1'b0, bus.a} + {1'b0, ~bus.b} + {{N{1'b0}}, 1'b1};
    assign ovf_add = (sum_add[N-1] ^ bus.a[N-1]) & ~(1'b0 ^ bus.b[N-1] ^ bus.a[N-1]);
    assign ovf_sub = (sum_sub[N-1] ^ bus.a[N-1]) & ~(1'b1 ^ bus.b[N-1] ^ bus.a[N-1]);

    assign mul_acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_o   = 1'b0;
        case (bus.op)
            OpAdd: begin
                alu_res = sum_add[N-1:0];
                alu_c   = sum_add[N];
                alu_o   = ovf_add;
            end
            OpSub: begin
                alu_res = sum_sub[N-1:0];
                alu_c   = sum_sub[N];
                alu_o   = ovf_sub;
            end
            OpAnd:   alu_res = bus.a & bus.b;
            OpOr:    alu_res = bus.a | bus.b;
            OpXor:   alu_res = bus.a ^ bus.b;
            OpSlt:   alu_res = {{(N-1){1'b0}}, sum_sub[N-1] ^ ovf_sub};
            OpSll:   alu_res = bus.a << bus.b[SW-1:0];
            default: alu_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (bus.op == OpMul) ? StMul : StDone;
                end
            end
            StMul: begin
                if (mul_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        bus.in_ready  = (state_q == StIdle) && !rst;
        bus.busy      = (state_q == StMul);
        bus.out_valid = (state_q == StDone);
        bus.result    = result_q;
        bus.carry     = carry_q;
        bus.overflow  = ovf_q;
        bus.zero      = zero_q;
        bus.negative  = neg_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        mcand_q  <= bus.a;
                        mplier_q <= bus.b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        if (bus.op != OpMul) begin
                            result_q <= alu_res;
                            carry_q  <= alu_c;
                            ovf_q    <= alu_o;
                            zero_q   <= (alu_res == '0);
                            neg_q    <= alu_res[N-1];
                        end
                    end
                end
                StMul: begin
                    acc_q    <= mul_acc_next;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (mul_last) begin
                        result_q <= mul_acc_next;
                        carry_q  <= 1'b0;
                        ovf_q    <= 1'b0;
                        zero_q   <= (mul_acc_next == '0);
                        neg_q    <= mul_acc_next[N-1];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed table, backpressure and reset-abort
// sequences, then random ops checked against a plain-arithmetic reference model.
module tb_alu_seq;
    localparam int unsigned N = 32;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        c;
        logic        o;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_seq_if #(.N(N)) bus ();
    alu_seq #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_model(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] r,
                                      output logic c, output logic o);
        longint          sa = $signed(a);
        longint          sb = $signed(b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint          s;
        r = '0;
        c = 1'b0;
        o = 1'b0;
        case (op)
            3'd0: begin
                s = sa + sb;
                r = 32'(ua + ub);
                c = ((ua + ub) >> 32) != 0;
                o = (s != longint'($signed(r)));
            end
            3'd1: begin
                s = sa - sb;
                r = a - b;
                c = (a >= b);
                o = (s != longint'($signed(r)));
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd6: r = a << b[4:0];
            default: r = 32'(ua * ub);
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ec, input logic eo,
                          input string nm);
        int t;
        int lat;
        int busy_n;
        int exp_lat;
        t = 0;
        while (!bus.in_ready && t < 200) begin
            tick();
            t++;
        end
        chk({nm, " in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        tick();
        bus.in_valid = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.op = 3'($urandom);
        lat = 0;
        busy_n = 0;
        while (!bus.out_valid && lat < 200) begin
            if (bus.busy) busy_n++;
            tick();
            lat++;
        end
        exp_lat = (op == 3'd7) ? N : 0;
        chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, " busy cycles"}, 64'(busy_n), 64'(exp_lat));
        chk({nm, " result"}, 64'(bus.result), 64'(er));
        chk({nm, " carry"}, 64'(bus.carry), 64'(ec));
        chk({nm, " overflow"}, 64'(bus.overflow), 64'(eo));
        chk({nm, " zero"}, 64'(bus.zero), 64'(er == 32'd0));
        chk({nm, " negative"}, 64'(bus.negative), 64'(er[31]));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({nm, " out_valid drop"}, 64'(bus.out_valid), 64'd0);
    endtask

    vec_t tbl[16];
    logic [31:0] edge_v[5];

    initial begin
        logic [31:0] ra, rb, er;
        logic        ec, eo;
        logic [2:0]  rop;
        int          ov_seen;

        tbl[0]  = '{3'd0, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b1, "add_ovf"};
        tbl[1]  = '{3'd1, 32'h5,         32'h5,         32'h0,         1'b1, 1'b0, "sub_eq"};
        tbl[2]  = '{3'd1, 32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0, 1'b0, "sub_borrow"};
        tbl[3]  = '{3'd5, 32'h8000_0000, 32'h1,         32'h1,         1'b0, 1'b0, "slt_neg"};
        tbl[4]  = '{3'd5, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0, "slt_ovf"};
        tbl[5]  = '{3'd5, 32'h1234,      32'h1234,      32'h0,         1'b0, 1'b0, "slt_eq"};
        tbl[6]  = '{3'd7, 32'h1_0000,    32'h1_0000,    32'h0,         1'b0, 1'b0, "mul_wrap"};
        tbl[7]  = '{3'd7, 32'h7,         32'h6,         32'd42,        1'b0, 1'b0, "mul_42"};
        tbl[8]  = '{3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, "and"};
        tbl[9]  = '{3'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, "or"};
        tbl[10] = '{3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, "xor"};
        tbl[11] = '{3'd6, 32'h1,         32'd31,        32'h8000_0000, 1'b0, 1'b0, "sll_31"};
        tbl[12] = '{3'd6, 32'hABCD,      32'd0,         32'hABCD,      1'b0, 1'b0, "sll_0"};
        tbl[13] = '{3'd6, 32'h1,         32'h24,        32'h10,        1'b0, 1'b0, "sll_trunc"};
        tbl[14] = '{3'd0, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0, "add_carry"};
        tbl[15] = '{3'd1, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf"};
        edge_v  = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = 3'd0;
        bus.a         = '0;
        bus.b         = '0;

        rst = 1'b1;
        tick();
        tick();
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset in_ready", 64'(bus.in_ready), 64'd0);
        chk("reset result", 64'(bus.result), 64'd0);
        chk("reset flags", 64'({bus.carry, bus.overflow, bus.zero, bus.negative}), 64'd0);
        rst = 1'b0;
        #1;
        chk("post-reset in_ready", 64'(bus.in_ready), 64'd1);

        for (int i = 0; i < 16; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].c, tbl[i].o, tbl[i].name);
        end

        // Backpressure: XOR result held while a new op waits on in_valid.
        bus.in_valid = 1'b1;
        bus.op = 3'd4;
        bus.a = 32'hA5A5_A5A5;
        bus.b = 32'h0F0F_0F0F;
        tick();
        bus.op = 3'd0;
        bus.a = 32'd1;
        bus.b = 32'd2;
        for (int i = 0; i < 5; i++) begin
            chk("bp out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp result", 64'(bus.result), 64'hAAAA_AAAA);
            chk("bp flags", 64'({bus.carry, bus.overflow, bus.zero, bus.negative}), 64'b0001);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp release in_ready", 64'(bus.in_ready), 64'd1);
        chk("bp release out_valid", 64'(bus.out_valid), 64'd0);
        tick();
        bus.in_valid = 1'b0;
        chk("bp next out_valid", 64'(bus.out_valid), 64'd1);
        chk("bp next result", 64'(bus.result), 64'd3);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Reset ten cycles into a MUL must drop the product silently.
        bus.in_valid = 1'b1;
        bus.op = 3'd7;
        bus.a = 32'h7;
        bus.b = 32'h6;
        tick();
        bus.in_valid = 1'b0;
        repeat (9) tick();
        chk("abort busy before rst", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        tick();
        chk("abort out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort busy", 64'(bus.busy), 64'd0);
        chk("abort result", 64'(bus.result), 64'd0);
        chk("abort flags", 64'({bus.carry, bus.overflow, bus.zero, bus.negative}), 64'd0);
        chk("abort in_ready in rst", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("abort in_ready", 64'(bus.in_ready), 64'd1);
        ov_seen = 0;
        for (int i = 0; i < N + 8; i++) begin
            tick();
            if (bus.out_valid) ov_seen++;
        end
        chk("abort never presented", 64'(ov_seen), 64'd0);

        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = $urandom_range(0, 15); rb = $urandom_range(0, 40); end
                default: begin
                    ra = edge_v[$urandom_range(0, 4)];
                    rb = edge_v[$urandom_range(0, 4)];
                end
            endcase
            ref_model(rop, ra, rb, er, ec, eo);
            run_op(rop, ra, rb, er, ec, eo, $sformatf("rand%0d op%0d", i, rop));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
